// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: pixel write / swap handshake and matrix drive lines of the LED scanner
interface led_matrix_scanner_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  logic wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic wr_red;
  logic wr_green;
  logic swap_req;
  logic swap_ack;
  logic [COLS-1:0] red_cols;
  logic [COLS-1:0] green_cols;
  logic [ROWS-1:0] row_sink;
  logic frame_start;
  modport master (
    output wr_en, wr_row, wr_col, wr_red, wr_green, swap_req,
    input swap_ack, red_cols, green_cols, row_sink, frame_start
  );
  modport slave (
    input wr_en, wr_row, wr_col, wr_red, wr_green, swap_req,
    output swap_ack, red_cols, green_cols, row_sink, frame_start
  );
endinterface

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: double-buffered bi-colour LED matrix row scanner with blanking and tear-free swap
module led_matrix_scanner #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DWELL = 5000,
  parameter int BLANK = 50
) (
  input logic clk,
  input logic reset,
  led_matrix_scanner_if.slave bus
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int MX = DWELL > BLANK ? DWELL : BLANK;
  localparam int NW = $clog2(MX + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [NW-1:0] BLANK_N = NW'(BLANK);
  localparam logic [NW-1:0] DWELL_N = NW'(DWELL);
  typedef enum logic {S_BLANK, S_DRIVE} state_t;
  state_t state, state_n;
  logic [RW-1:0] row, row_n;
  logic [NW-1:0] cnt, cnt_n;
  logic sel, pending, do_swap, wr_ok, drive;
  logic [COLS-1:0] red_buf [2][ROWS];
  logic [COLS-1:0] green_buf [2][ROWS];
  assign wr_ok = bus.wr_en && 32'(bus.wr_row) < ROWS && 32'(bus.wr_col) < COLS;
  assign drive = state_n == S_DRIVE;
  // cnt is 1-based; the reset value 0 is a pre-frame cycle so the first post-reset edge is blank cycle 1
  always_comb begin
    state_n = state;
    row_n = row;
    cnt_n = cnt + 1'b1;
    do_swap = 1'b0;
    if (state == S_BLANK && cnt == BLANK_N) begin
      state_n = S_DRIVE;
      cnt_n = NW'(1);
    end
    if (state == S_DRIVE && cnt == DWELL_N) begin
      state_n = S_BLANK;
      cnt_n = NW'(1);
      row_n = row == LAST_ROW ? '0 : row + 1'b1;
      do_swap = row == LAST_ROW && (pending || bus.swap_req);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_BLANK;
      row <= '0;
      cnt <= '0;
      sel <= 1'b0;
      pending <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++) begin
          red_buf[b][r] <= '0;
          green_buf[b][r] <= '0;
        end
      bus.row_sink <= '1;
      bus.red_cols <= '0;
      bus.green_cols <= '0;
      bus.swap_ack <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      state <= state_n;
      row <= row_n;
      cnt <= cnt_n;
      sel <= sel ^ do_swap;
      pending <= !do_swap && (pending || bus.swap_req);
      if (wr_ok) begin
        red_buf[~sel][bus.wr_row][bus.wr_col] <= bus.wr_red;
        green_buf[~sel][bus.wr_row][bus.wr_col] <= bus.wr_green;
      end
      bus.row_sink <= drive ? ~(ROWS'(1) << row_n) : '1;
      bus.red_cols <= drive ? red_buf[sel][row_n] : '0;
      bus.green_cols <= drive ? green_buf[sel][row_n] : '0;
      bus.swap_ack <= do_swap;
      bus.frame_start <= state_n == S_BLANK && row_n == '0 && cnt_n == NW'(1);
    end
  end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: randomized self-checking bench against a cycle-position reference model
module tb_led_matrix_scanner;
  localparam int ROWS = 8, COLS = 8, DWELL = 4, BLANK = 2;
  localparam int RP = BLANK + DWELL, FP = ROWS * RP;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus();
  led_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  logic [7:0] img_r [2][8];
  logic [7:0] img_g [2][8];
  bit msel, mpend;
  int t;
  logic [25:0] exp_v;
  int checks = 0, fails = 0;
  function automatic logic [25:0] obs();
    return {bus.row_sink, bus.red_cols, bus.green_cols, bus.swap_ack, bus.frame_start};
  endfunction
  function automatic int pos();
    return (t - 1) % FP;
  endfunction
  // model: outputs follow from the position of the cycle within the frame since reset release
  task automatic tick(input logic rs, input logic we, input logic [2:0] r, input logic [2:0] c,
                      input logic rd, input logic gr, input logic sr);
    int p, rr, ph;
    bit sw;
    reset = rs; bus.wr_en = we; bus.wr_row = r; bus.wr_col = c;
    bus.wr_red = rd; bus.wr_green = gr; bus.swap_req = sr;
    @(posedge clk);
    if (rs) begin
      t = 0; msel = 1'b0; mpend = 1'b0;
      for (int b = 0; b < 2; b++) for (int k = 0; k < 8; k++) begin img_r[b][k] = '0; img_g[b][k] = '0; end
      exp_v = {8'hFF, 16'h0, 1'b0, 1'b0};
    end else begin
      t++;
      p = (t - 1) % FP;
      sw = t > 1 && p == 0 && (mpend || sr);
      if (we) begin img_r[msel ^ 1'b1][r][c] = rd; img_g[msel ^ 1'b1][r][c] = gr; end
      mpend = !sw && (mpend || sr);
      msel = msel ^ sw;
      rr = p / RP; ph = p % RP;
      exp_v = ph < BLANK ? {8'hFF, 16'h0, sw, p == 0}
                         : {~(8'd1 << rr), img_r[msel][rr], img_g[msel][rr], 1'b0, 1'b0};
    end
    #1;
  endtask
  task automatic idle();
    tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic advance_to(input int p);
    while (pos() != p) idle();
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs() !== 26'({8'hFF, 16'h0, 1'b0, 1'b0})) begin
        fails++; $display("FAIL reset_hold cycle=%0d got=%h exp=%h", i, obs(), {8'hFF, 16'h0, 2'b00});
      end
    end
    idle();
    checks++;
    if (bus.frame_start !== 1'b1 || bus.row_sink !== 8'hFF) begin
      fails++; $display("FAIL reset_release frame_start=%b row_sink=%h exp 1/ff", bus.frame_start, bus.row_sink);
    end
  endtask
  task automatic test_scan();
    int fs = 0;
    for (int i = 0; i < 2 * FP; i++) begin
      idle();
      fs += bus.frame_start;
      checks++;
      if (obs() !== exp_v) begin fails++; $display("FAIL scan t=%0d got=%h exp=%h", t, obs(), exp_v); end
    end
    checks++;
    if (fs != 2) begin fails++; $display("FAIL scan_frame_pulses got=%0d exp=2", fs); end
  endtask
  task automatic test_write_swap();
    int acks = 0;
    bit seen = 1'b0;
    advance_to(0);
    tick(1'b0, 1'b1, 3'd3, 3'd5, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0);
    advance_to(2 * RP + 2);
    tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2 * FP; i++) begin
      idle();
      acks += bus.swap_ack;
      if (bus.swap_ack) begin
        seen = 1'b1;
        checks++;
        if (pos() != 0) begin fails++; $display("FAIL ws_ack_pos got=%0d exp=0", pos()); end
      end
      if (!seen && (bus.red_cols | bus.green_cols) != 8'h00) begin
        checks++; fails++; $display("FAIL ws_early_show red=%h green=%h exp=00", bus.red_cols, bus.green_cols);
      end
      if (seen && pos() == 3 * RP + BLANK) begin
        checks++;
        if (bus.red_cols !== 8'h20 || bus.green_cols !== 8'h01) begin
          fails++; $display("FAIL ws_row3 red=%h green=%h exp=20/01", bus.red_cols, bus.green_cols);
        end
      end
      checks++;
      if (obs() !== exp_v) begin fails++; $display("FAIL ws t=%0d got=%h exp=%h", t, obs(), exp_v); end
    end
    checks++;
    if (acks != 1) begin fails++; $display("FAIL ws_ack_count got=%0d exp=1", acks); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 4 * FP; i++) begin
      tick(1'b0, 1'($urandom_range(0, 3) == 0), 3'($urandom), 3'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom_range(0, 29) == 0));
      checks++;
      if (obs() !== exp_v) begin fails++; $display("FAIL random t=%0d got=%h exp=%h", t, obs(), exp_v); end
    end
    for (int i = 0; i < FP; i++) idle();
  endtask
  task automatic test_coalesce();
    int acks = 0, a, b, c;
    bit s0;
    advance_to(3);
    s0 = msel;
    a = $urandom_range(5, 15); b = $urandom_range(16, 30); c = $urandom_range(31, 44);
    for (int i = 0; i < 2 * FP - 4; i++) begin
      tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'(pos() + 1 == a || pos() + 1 == b || pos() + 1 == c));
      acks += bus.swap_ack;
      checks++;
      if (obs() !== exp_v) begin fails++; $display("FAIL coalesce t=%0d got=%h exp=%h", t, obs(), exp_v); end
    end
    checks++;
    if (acks != 1) begin fails++; $display("FAIL coalesce_acks got=%0d exp=1", acks); end
    checks++;
    if (dut.sel !== (s0 ^ 1'b1)) begin fails++; $display("FAIL coalesce_sel got=%b exp=%b", dut.sel, s0 ^ 1'b1); end
  endtask
  task automatic test_boundary();
    advance_to(FP - 1);
    tick(1'b0, 1'b1, 3'd7, 3'd7, 1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.swap_ack !== 1'b1 || bus.frame_start !== 1'b1) begin
      fails++; $display("FAIL boundary_ack ack=%b fs=%b exp 1/1", bus.swap_ack, bus.frame_start);
    end
    for (int i = 0; i < FP - 1; i++) begin
      idle();
      if (pos() == 7 * RP + BLANK) begin
        checks++;
        if (bus.red_cols[7] !== 1'b1) begin fails++; $display("FAIL boundary_row7 red=%h exp bit7 set", bus.red_cols); end
      end
      checks++;
      if (obs() !== exp_v) begin fails++; $display("FAIL boundary t=%0d got=%h exp=%h", t, obs(), exp_v); end
    end
  endtask
  task automatic test_reset_mid();
    int acks = 0;
    advance_to(5);
    tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    advance_to(4 * RP + BLANK + 1);
    tick(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.row_sink !== 8'hFF || bus.red_cols !== 8'h00 || bus.green_cols !== 8'h00) begin
      fails++; $display("FAIL midreset sink=%h red=%h green=%h exp ff/00/00", bus.row_sink, bus.red_cols, bus.green_cols);
    end
    for (int i = 0; i < 2 * FP; i++) begin
      idle();
      acks += bus.swap_ack;
      checks++;
      if (obs() !== exp_v || (bus.red_cols | bus.green_cols) !== 8'h00) begin
        fails++; $display("FAIL midreset_run t=%0d got=%h exp=%h", t, obs(), exp_v);
      end
    end
    checks++;
    if (acks != 0 || dut.sel !== 1'b0) begin fails++; $display("FAIL midreset_swap acks=%0d sel=%b exp 0/0", acks, dut.sel); end
  endtask
  initial begin
    bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
    bus.wr_red = 1'b0; bus.wr_green = 1'b0; bus.swap_req = 1'b0;
    test_reset();
    test_scan();
    test_write_swap();
    test_random();
    test_coalesce();
    test_boundary();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
